// File: rtl/kbd_port_pkg.sv
// Shared constants for the port-mapped keyboard controller:
// port addresses, command codes, status/config bit indices, FSM states.
package kbd_port_pkg;

    localparam logic [15:0] PORT_DATA_DEF = 16'h0060;
    localparam logic [15:0] PORT_STAT_DEF = 16'h0064;

    localparam logic [7:0] CMD_RCFG    = 8'h20;
    localparam logic [7:0] CMD_WCFG    = 8'h60;
    localparam logic [7:0] CMD_KB_DIS  = 8'hAD;
    localparam logic [7:0] CMD_KB_EN   = 8'hAE;
    localparam logic [7:0] CMD_IRQ_DIS = 8'hA7;
    localparam logic [7:0] CMD_IRQ_EN  = 8'hA8;
    localparam logic [7:0] CMD_FLUSH   = 8'hC0;

    localparam int ST_OBF    = 0;
    localparam int ST_SYS    = 2;
    localparam int ST_OVF    = 4;
    localparam int ST_IRQ_EN = 5;

    localparam int CFG_IRQ_EN = 0;
    localparam int CFG_KB_DIS = 4;

    localparam logic [7:0] CFG_RESET = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RCFG = 2'd1,
        WCFG = 2'd2
    } cmd_state_e;

    function automatic logic [7:0] status_byte(
        input logic irq_en,
        input logic ovf,
        input logic obf
    );
        logic [7:0] s;
        s = 8'h00;
        s[ST_OBF]    = obf;
        s[ST_SYS]    = 1'b1;
        s[ST_OVF]    = ovf;
        s[ST_IRQ_EN] = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/kbd_port_if.sv
// Core I/O port bus and interrupt lines as seen by the keyboard controller.
interface kbd_port_if;
    logic [15:0] port_a;
    logic        port_r;
    logic        port_w;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic        irq;
    logic [7:0]  irq_in;

    modport master (
        output port_a, port_r, port_w, port_o,
        input  port_i, irq, irq_in
    );

    modport slave (
        input  port_a, port_r, port_w, port_o,
        output port_i, irq, irq_in
    );
endinterface

// File: rtl/kbd_port_fifo.sv
// Synchronous byte FIFO with same-cycle push/pop and flush.
module kbd_fifo
    import kbd_port_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   cnt_nxt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] P_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   C_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   C_FULL = DEPTH[DEPTH_LOG2:0];

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  pop_ok, push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == C_FULL);
    assign count   = cnt_q;
    assign cnt_nxt = cnt_d;
    assign rdata   = mem_q[rp_q];
    assign pop_ok  = pop && !empty;
    // A pop frees the slot the same-cycle push needs, even when full.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wp_d = wp_q + P_ONE;
            if (pop_ok)  rp_d = rp_q + P_ONE;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + C_ONE;
                2'b01:   cnt_d = cnt_q - C_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            if (push_ok && !flush) mem_q[wp_q] <= wdata;
        end
    end
endmodule

// File: rtl/kbd_port.sv
// 8042-style keyboard controller: data/status ports, scancode FIFO,
// two-phase config commands and a level interrupt request.
module kbd_port
    import kbd_port_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] PORT_DATA  = PORT_DATA_DEF,
    parameter logic [15:0] PORT_STAT  = PORT_STAT_DEF,
    parameter logic [7:0]  IRQ_VECTOR = 8'h09
) (
    input  logic       clock,
    input  logic       reset_n,
    kbd_port_if.slave  bus,
    input  logic [7:0] kb_data,
    input  logic       kb_done
);
    cmd_state_e          state_q, state_d;
    logic [7:0]          cfg_q, cfg_d;
    logic [7:0]          last_q, last_d;
    logic                ovf_q, ovf_d;
    logic                irq_q, irq_d;
    logic                sel_data, sel_stat;
    logic                pop, push_req, push, flush;
    logic [7:0]          head;
    logic                empty, full;
    logic [DEPTH_LOG2:0] count, cnt_nxt;

    assign sel_data = (bus.port_a == PORT_DATA);
    assign sel_stat = (bus.port_a == PORT_STAT);
    assign pop      = bus.port_r && sel_data && state_q != RCFG && !empty;
    assign push_req = kb_done && !cfg_q[CFG_KB_DIS];
    assign push     = push_req;
    assign flush    = bus.port_w && sel_stat && bus.port_o == CMD_FLUSH;

    kbd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (kb_data),
        .rdata   (head),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .cnt_nxt (cnt_nxt)
    );

    always_comb begin
        bus.port_i = 8'h00;
        unique case (1'b1)
            sel_data: bus.port_i = (state_q == RCFG) ? cfg_q
                                 : (!empty ? head : last_q);
            sel_stat: bus.port_i = status_byte(cfg_q[CFG_IRQ_EN],
                                               ovf_q, !empty);
            default:  bus.port_i = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (pop) last_d = head;
        if (bus.port_r && sel_stat) ovf_d = 1'b0;
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (bus.port_r && sel_data && state_q == RCFG) state_d = IDLE;
        if (bus.port_w && sel_data && state_q == WCFG) begin
            cfg_d   = bus.port_o;
            state_d = IDLE;
        end
        // Any command aborts a pending phase before being decoded.
        if (bus.port_w && sel_stat) begin
            state_d = IDLE;
            unique case (bus.port_o)
                CMD_RCFG:    state_d = RCFG;
                CMD_WCFG:    state_d = WCFG;
                CMD_KB_DIS:  cfg_d[CFG_KB_DIS] = 1'b1;
                CMD_KB_EN:   cfg_d[CFG_KB_DIS] = 1'b0;
                CMD_IRQ_DIS: cfg_d[CFG_IRQ_EN] = 1'b0;
                CMD_IRQ_EN:  cfg_d[CFG_IRQ_EN] = 1'b1;
                CMD_FLUSH:   ovf_d = 1'b0;
                default:     state_d = IDLE;
            endcase
        end
        irq_d = cfg_d[CFG_IRQ_EN] && (cnt_nxt != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cfg_q   <= CFG_RESET;
            last_q  <= 8'h00;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.irq    = irq_q;
    assign bus.irq_in = IRQ_VECTOR;
endmodule

// File: tb/tb_kbd_port.sv
// Scoreboarded directed bench for kbd_port: reads queue expected data,
// a negedge monitor checks port_i whenever a read strobe is presented.
module tb_kbd_port;
    import kbd_port_pkg::*;

    logic       clock;
    logic       reset_n;
    logic [7:0] kb_data;
    logic       kb_done;
    int         vectors;
    int         miscompares;

    logic [7:0] sb_exp [$];
    string      sb_name [$];

    kbd_port_if bus ();

    kbd_port dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .kb_data (kb_data),
        .kb_done (kb_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.port_r) begin
            vectors++;
            if (sb_exp.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read got=%02h", bus.port_i);
            end else begin
                logic [7:0] e;
                string      n;
                e = sb_exp.pop_front();
                n = sb_name.pop_front();
                if (bus.port_i !== e) begin
                    miscompares++;
                    $display("FAIL %s got=%02h exp=%02h", n, bus.port_i, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] got,
                       input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%02h exp=%02h", n, got, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e,
                      input string n);
        bus.port_a = a;
        bus.port_r = 1'b1;
        sb_exp.push_back(e);
        sb_name.push_back(n);
        tick();
        bus.port_r = 1'b0;
        kb_done    = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.port_a = a;
        bus.port_o = d;
        bus.port_w = 1'b1;
        tick();
        bus.port_w = 1'b0;
    endtask

    task automatic kb(input logic [7:0] d);
        kb_data = d;
        kb_done = 1'b1;
        tick();
        kb_done = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        kb_data     = 8'h00;
        kb_done     = 1'b0;
        bus.port_a  = 16'h0000;
        bus.port_r  = 1'b0;
        bus.port_w  = 1'b0;
        bus.port_o  = 8'h00;
        #12 reset_n = 1'b1;
        tick();

        chk("rst_irq", {7'b0, bus.irq}, 8'h00);
        chk("rst_port_i", bus.port_i, 8'h00);
        chk("irq_vector", bus.irq_in, 8'h09);
        rd(16'h0060, 8'h00, "rst_last");
        rd(16'h0064, 8'h24, "rst_stat");

        kb(8'h1C);
        chk("irq_after_push", {7'b0, bus.irq}, 8'h01);
        rd(16'h0064, 8'h25, "stat_one");
        rd(16'h0060, 8'h1C, "data_one");
        chk("irq_after_pop", {7'b0, bus.irq}, 8'h00);
        rd(16'h0060, 8'h1C, "last_repeat");
        rd(16'h0064, 8'h24, "stat_empty");

        for (int i = 1; i <= 9; i++) kb(8'(i));
        rd(16'h0064, 8'h35, "stat_ovf");
        for (int i = 1; i <= 8; i++) rd(16'h0060, 8'(i), "ovf_data");
        rd(16'h0064, 8'h24, "stat_ovf_clr");

        for (int i = 1; i <= 8; i++) kb(8'(i));
        kb_data = 8'hAA;
        kb_done = 1'b1;
        rd(16'h0060, 8'h01, "full_pushpop");
        rd(16'h0064, 8'h25, "full_pushpop_stat");
        for (int i = 2; i <= 8; i++) rd(16'h0060, 8'(i), "full_data");
        rd(16'h0060, 8'hAA, "full_late_byte");
        rd(16'h0064, 8'h24, "full_drained");

        kb(8'h01);
        wr(16'h0064, 8'h20);
        rd(16'h0060, 8'h01, "rcfg_read");
        rd(16'h0064, 8'h25, "rcfg_no_pop");
        wr(16'h0064, 8'h60);
        wr(16'h0060, 8'h10);
        chk("wcfg_irq_off", {7'b0, bus.irq}, 8'h00);
        rd(16'h0064, 8'h05, "wcfg_stat");
        kb(8'h1E);
        chk("kbdis_irq", {7'b0, bus.irq}, 8'h00);
        rd(16'h0060, 8'h01, "kbdis_data");
        rd(16'h0064, 8'h04, "kbdis_empty");
        wr(16'h0064, 8'h60);
        wr(16'h0060, 8'h01);

        wr(16'h0064, 8'hA7);
        kb(8'h2A);
        chk("a7_irq", {7'b0, bus.irq}, 8'h00);
        rd(16'h0064, 8'h05, "a7_stat");
        wr(16'h0064, 8'hA8);
        chk("a8_irq", {7'b0, bus.irq}, 8'h01);
        rd(16'h0064, 8'h25, "a8_stat");
        wr(16'h0064, 8'hC0);
        chk("flush_irq", {7'b0, bus.irq}, 8'h00);
        rd(16'h0064, 8'h24, "flush_stat");
        wr(16'h0064, 8'hAD);
        kb(8'h55);
        rd(16'h0064, 8'h24, "ad_drop");
        wr(16'h0064, 8'hAE);
        kb(8'h56);
        rd(16'h0060, 8'h56, "ae_data");

        kb(8'h11);
        kb(8'h12);
        kb(8'h13);
        wr(16'h0064, 8'h60);
        bus.port_a = 16'h0064;
        #2 reset_n = 1'b0;
        #1;
        chk("async_irq", {7'b0, bus.irq}, 8'h00);
        chk("async_stat", bus.port_i, 8'h24);
        #3 reset_n = 1'b1;
        tick();
        wr(16'h0060, 8'h00);
        rd(16'h0064, 8'h24, "post_rst_stat");
        rd(16'h0060, 8'h00, "post_rst_data");

        tick();
        tick();
        chk("sb_drained", 8'(sb_exp.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
